perf_counter_bank: RTL and testbench

Parametrised bank of hardware performance counters for the pipelined LC-3b core. It generalises the fixed branch, mispredict, IF-stall and MEM-stall counters into NUM_CNT event channels of configurable width, with wrap or saturate mode and sticky overflow flags. It also provides a freeze control, a coherent snapshot with a request/acknowledge handshake, and an indexed registered read port. It sits beside the datapath: stage event strobes feed it, and the debug or memory-mapped read logic consumes it.

---
 rtl/perf_counter_bank.sv | 175 +++++++++++++++++
 tb/tb_perf_counter_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - event counter bank with snapshot and read port; optional PERF_CNT_THRESH_EN threshold pulse
module perf_counter_bank #(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 16,
  parameter int SATURATE  = 0,
  parameter int IDX_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CNT-1:0]           event_in,
  input  logic [NUM_CNT-1:0]           clear,
  input  logic                         freeze,
  input  logic                         snap_req,
  input  logic                         snap_ack,
  output logic                         snap_valid,
  input  logic [IDX_WIDTH-1:0]         rd_idx,
  input  logic                         rd_shadow,
  output logic [CNT_WIDTH-1:0]         rd_data,
  output logic [NUM_CNT-1:0]           overflow,
`ifdef PERF_CNT_THRESH_EN
  input  logic [CNT_WIDTH-1:0]         thresh_val,
  output logic [NUM_CNT-1:0]           thresh_hit,
`endif
  output logic [NUM_CNT*CNT_WIDTH-1:0] cnt_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } snap_state_t;

  snap_state_t          state_q;
  snap_state_t          state_d;
  logic                 capture;
  logic [CNT_WIDTH-1:0] cnt_q    [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d    [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];
  logic [NUM_CNT-1:0]   ovf_q;
  logic [NUM_CNT-1:0]   ovf_d;
  logic [CNT_WIDTH-1:0] rd_sel;

  // Per-channel next count: clear beats freeze, freeze beats the event strobe
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clear[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (!freeze && event_in[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          // At max: wrap mode rolls to zero, saturate mode holds; both flag it
          ovf_d[i] = 1'b1;
          if (SATURATE == 0) begin
            cnt_d[i] = '0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Snapshot FSM: capture in IDLE on request, hold until acknowledged (ack wins over req)
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    snap_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (snap_req) begin
          state_d = S_HOLD;
          capture = 1'b1;
        end
      end
      S_HOLD: begin
        snap_valid = 1'b1;
        if (snap_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read mux: indices with no channel behind them read as zero
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_WIDTH'(i)) begin
        rd_sel = rd_shadow ? shadow_q[i] : cnt_q[i];
      end
    end
  end

  // Live counters and sticky overflow flags
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Snapshot state and shadow copies; shadows take the pre-update counts so all channels agree
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (capture) begin
        for (int i = 0; i < NUM_CNT; i++) begin
          shadow_q[i] <= cnt_q[i];
        end
      end
    end
  end

  // Registered read data, one cycle behind the index
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_sel;
    end
  end

  // Flatten live counters straight from the registers
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_out[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

  assign overflow = ovf_q;

`ifdef PERF_CNT_THRESH_EN
  logic [NUM_CNT-1:0] hit_d;

  // A real increment landing on thresh_val; saturated holds and clears never qualify
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (!clear[i] && !freeze && event_in[i] &&
          !((SATURATE != 0) && (cnt_q[i] == CNT_MAX)) &&
          ((cnt_q[i] + CNT_ONE) == thresh_val)) begin
        hit_d[i] = 1'b1;
      end
    end
  end

  // One-cycle threshold pulse, aligned with the first cycle the counter shows the value
  always_ff @(posedge clk) begin
    if (reset) begin
      thresh_hit <= '0;
    end else begin
      thresh_hit <= hit_d;
    end
  end
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - randomized and directed checks of perf_counter_bank against a reference model
module tb_perf_counter_bank;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     event_in;
  logic [3:0]     clear;
  logic           freeze;
  logic           snap_req;
  logic           snap_ack;
  logic [1:0]     rd_idx;
  logic           rd_shadow;
  logic           snap_valid_w, snap_valid_s;
  logic [W-1:0]   rd_data_w, rd_data_s;
  logic [3:0]     overflow_w;
  logic [2:0]     overflow_s;
  logic [4*W-1:0] cnt_w;
  logic [3*W-1:0] cnt_s;
`ifdef PERF_CNT_THRESH_EN
  logic [W-1:0]   thresh_val = 4'd4;
  logic [3:0]     thresh_hit_w;
  logic [2:0]     thresh_hit_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt [2][4];
  int m_shd [2][4];
  int m_rd  [2];
  bit m_ovf [2][4];
  bit m_hit [2][4];
  bit m_hold[2];

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(W), .SATURATE(0), .IDX_WIDTH(2)) dut_w (
    .clk(clk), .reset(reset), .event_in(event_in), .clear(clear), .freeze(freeze),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(snap_valid_w),
    .rd_idx(rd_idx), .rd_shadow(rd_shadow), .rd_data(rd_data_w), .overflow(overflow_w),
`ifdef PERF_CNT_THRESH_EN
    .thresh_val(thresh_val), .thresh_hit(thresh_hit_w),
`endif
    .cnt_out(cnt_w)
  );

  perf_counter_bank #(.NUM_CNT(3), .CNT_WIDTH(W), .SATURATE(1), .IDX_WIDTH(2)) dut_s (
    .clk(clk), .reset(reset), .event_in(event_in[2:0]), .clear(clear[2:0]), .freeze(freeze),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(snap_valid_s),
    .rd_idx(rd_idx), .rd_shadow(rd_shadow), .rd_data(rd_data_s), .overflow(overflow_s),
`ifdef PERF_CNT_THRESH_EN
    .thresh_val(thresh_val), .thresh_hit(thresh_hit_s),
`endif
    .cnt_out(cnt_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: k=0 is the 4-channel wrap bank, k=1 the 3-channel saturating bank
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 0) ? 4 : 3;
      if (reset) begin
        m_rd[k]   = 0;
        m_hold[k] = 0;
        for (int i = 0; i < 4; i++) begin
          m_cnt[k][i] = 0; m_shd[k][i] = 0; m_ovf[k][i] = 0; m_hit[k][i] = 0;
        end
      end else begin
        if (int'(rd_idx) < n) m_rd[k] = rd_shadow ? m_shd[k][rd_idx] : m_cnt[k][rd_idx];
        else m_rd[k] = 0;
        if (!m_hold[k] && snap_req) begin
          m_hold[k] = 1;
          for (int i = 0; i < 4; i++) m_shd[k][i] = m_cnt[k][i];
        end else if (m_hold[k] && snap_ack) begin
          m_hold[k] = 0;
        end
        for (int i = 0; i < n; i++) begin
          m_hit[k][i] = 0;
          if (clear[i]) begin
            m_cnt[k][i] = 0;
            m_ovf[k][i] = 0;
          end else if (!freeze && event_in[i]) begin
            if (k == 1 && m_cnt[k][i] == 15) begin
              m_ovf[k][i] = 1;
            end else begin
              if (m_cnt[k][i] == 15) m_ovf[k][i] = 1;
              m_cnt[k][i] = (m_cnt[k][i] + 1) % 16;
              m_hit[k][i] = (m_cnt[k][i] == 4);
            end
          end
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w_cnt%0d", i), cnt_w[i*W +: W], m_cnt[0][i]);
      chk($sformatf("w_ovf%0d", i), overflow_w[i], m_ovf[0][i]);
`ifdef PERF_CNT_THRESH_EN
      chk($sformatf("w_hit%0d", i), thresh_hit_w[i], m_hit[0][i]);
`endif
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s_cnt%0d", i), cnt_s[i*W +: W], m_cnt[1][i]);
      chk($sformatf("s_ovf%0d", i), overflow_s[i], m_ovf[1][i]);
`ifdef PERF_CNT_THRESH_EN
      chk($sformatf("s_hit%0d", i), thresh_hit_s[i], m_hit[1][i]);
`endif
    end
    chk("w_snap_valid", snap_valid_w, m_hold[0]);
    chk("s_snap_valid", snap_valid_s, m_hold[1]);
    chk("w_rd_data", rd_data_w, m_rd[0]);
    chk("s_rd_data", rd_data_s, m_rd[1]);
  endtask

  task automatic cycle(input logic rst, input logic [3:0] ev, input logic [3:0] clr,
                       input logic frz, input logic req, input logic ack,
                       input logic [1:0] idx, input logic sh);
    reset = rst; event_in = ev; clear = clr; freeze = frz;
    snap_req = req; snap_ack = ack; rd_idx = idx; rd_shadow = sh;
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_cnt_w", cnt_w, 0);
    chk("reset_snap_valid", snap_valid_w, 0);

    // Wrap: 17 events on channel 0
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (17) cycle(0, 4'b0001, 0, 0, 0, 0, 0, 0);
    chk("wrap_cnt0", cnt_w[3:0], 1);
    chk("wrap_ovf0", overflow_w[0], 1);
    chk("wrap_others", cnt_w[15:4], 0);

    // Saturate: 20 events on channel 1, then clear
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) cycle(0, 4'b0010, 0, 0, 0, 0, 0, 0);
    chk("sat_cnt1", cnt_s[7:4], 15);
    chk("sat_ovf1", overflow_s[1], 1);
    cycle(0, 0, 4'b0010, 0, 0, 0, 0, 0);
    chk("sat_clr_cnt1", cnt_s[7:4], 0);
    chk("sat_clr_ovf1", overflow_s[1], 0);

    // Priority: clear beats event, freeze beats event
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (7) cycle(0, 4'b0100, 0, 0, 0, 0, 0, 0);
    chk("prio_cnt2_pre", cnt_w[11:8], 7);
    cycle(0, 4'b0100, 4'b0100, 0, 0, 0, 0, 0);
    chk("prio_clear_cnt2", cnt_w[11:8], 0);
    repeat (3) cycle(0, 4'b1111, 0, 0, 0, 0, 0, 0);
    repeat (5) cycle(0, 4'b1111, 0, 1, 0, 0, 0, 0);
    chk("freeze_hold", cnt_w, 16'h3333);

    // Snapshot at {3,5,9,2}
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 9; j++)
      cycle(0, {j < 2, j < 9, j < 5, j < 3}, 0, 0, 0, 0, 0, 0);
    chk("snap_pre", cnt_w, 16'h2953);
    cycle(0, 4'b1111, 0, 0, 1, 0, 0, 0);
    chk("snap_valid_on", snap_valid_w, 1);
    cycle(0, 4'b1111, 0, 0, 1, 0, 2, 1);
    chk("snap_shadow2", rd_data_w, 9);
    cycle(0, 4'b1111, 0, 0, 0, 0, 3, 1);
    chk("snap_shadow3", rd_data_w, 2);
    cycle(0, 4'b1111, 0, 0, 1, 1, 0, 0);
    chk("snap_ack_off", snap_valid_w, 0);

    // Read port: live counter 3 = 9, out-of-range on the 3-channel bank
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (9) cycle(0, 4'b1111, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 3, 0);
    chk("rd_live3", rd_data_w, 9);
    chk("rd_out_of_range", rd_data_s, 0);

    // Reset while holding a snapshot
    cycle(0, 4'b1111, 0, 0, 1, 0, 1, 1);
    cycle(0, 4'b1111, 0, 0, 0, 0, 1, 1);
    cycle(1, 4'b1111, 4'b0000, 0, 1, 0, 1, 1);
    chk("rst_hold_cnt", cnt_w, 0);
    chk("rst_hold_valid", snap_valid_w, 0);
    chk("rst_hold_rd", rd_data_w, 0);
    chk("rst_hold_ovf", overflow_w, 0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] ev;
      logic [3:0] cl;
      for (int i = 0; i < 4; i++) begin
        ev[i] = ($urandom_range(3) != 0);
        cl[i] = ($urandom_range(39) == 0);
      end
      cycle(($urandom_range(299) == 0), ev, cl, ($urandom_range(7) == 0),
            ($urandom_range(7) == 0), ($urandom_range(3) == 0),
            2'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
